// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master bus arbiter with round-robin tie break,
// a beat limit that forces rearbitration, and locked-ownership support.
// All outputs are registered; every state change is qualified by HREADY.
module bus_arbiter #(
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       HBUSREQ_1,
    input  logic       HBUSREQ_2,
    input  logic       HLOCK_1,
    input  logic       HLOCK_2,
    input  logic       HREADY,
    output logic       HGRANT_1,
    output logic       HGRANT_2,
    output logic [1:0] HMASTER,
    output logic [1:0] SEL,
    output logic       HMASTLOCK
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN_M1 = 2'b01,
        OWN_M2 = 2'b10
    } state_t;

    localparam logic [7:0] BEAT_LAST = 8'(MAX_BEATS - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] beat_cnt;
    logic [7:0] beat_nxt;
    logic       last_m2;
    logic       last_m2_nxt;
    logic       mastlock_nxt;

    // Next owner: tie goes to the master that did not own last.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (HBUSREQ_1 && HBUSREQ_2)
                    state_nxt = last_m2 ? OWN_M1 : OWN_M2;
                else if (HBUSREQ_1)
                    state_nxt = OWN_M1;
                else if (HBUSREQ_2)
                    state_nxt = OWN_M2;
            end
            OWN_M1: begin
                if (!HBUSREQ_1)
                    state_nxt = HBUSREQ_2 ? OWN_M2 : IDLE;
                else if (!HLOCK_1 && HBUSREQ_2 && beat_cnt == BEAT_LAST)
                    state_nxt = OWN_M2;
            end
            OWN_M2: begin
                if (!HBUSREQ_2)
                    state_nxt = HBUSREQ_1 ? OWN_M1 : IDLE;
                else if (!HLOCK_2 && HBUSREQ_1 && beat_cnt == BEAT_LAST)
                    state_nxt = OWN_M1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Beat counter, last-owner flag and lock qualifier for the next owner.
    always_comb begin
        beat_nxt     = beat_cnt;
        last_m2_nxt  = last_m2;
        mastlock_nxt = 1'b0;
        if (state_nxt != state || state_nxt == IDLE)
            beat_nxt = '0;
        else if (beat_cnt != BEAT_LAST)
            beat_nxt = beat_cnt + 8'd1;
        if (state_nxt == OWN_M1) begin
            last_m2_nxt  = 1'b0;
            mastlock_nxt = HLOCK_1;
        end else if (state_nxt == OWN_M2) begin
            last_m2_nxt  = 1'b1;
            mastlock_nxt = HLOCK_2;
        end
    end

    // State and output registers; everything holds while HREADY is low.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            last_m2   <= 1'b1;
            HGRANT_1  <= 1'b0;
            HGRANT_2  <= 1'b0;
            HMASTER   <= '0;
            SEL       <= '0;
            HMASTLOCK <= 1'b0;
        end else if (HREADY) begin
            state     <= state_nxt;
            beat_cnt  <= beat_nxt;
            last_m2   <= last_m2_nxt;
            HGRANT_1  <= (state_nxt == OWN_M1);
            HGRANT_2  <= (state_nxt == OWN_M2);
            HMASTER   <= state_nxt;
            SEL       <= HMASTER;
            HMASTLOCK <= mastlock_nxt;
        end
    end

endmodule
